// File: rtl/drive_json_pkg.sv
// Shared types, ASCII codes and sizing helpers for the JSON drive-frame serializer.
package drive_json_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CONVERT,
        EMIT
    } state_t;

    localparam logic [7:0] LBRACE = 8'h7B;
    localparam logic [7:0] RBRACE = 8'h7D;
    localparam logic [7:0] QUOTE  = 8'h22;
    localparam logic [7:0] COLON  = 8'h3A;
    localparam logic [7:0] COMMA  = 8'h2C;
    localparam logic [7:0] MINUS  = 8'h2D;
    localparam logic [7:0] DOT    = 8'h2E;
    localparam logic [7:0] LF     = 8'h0A;
    localparam logic [7:0] ZERO   = 8'h30;

    function automatic int pow10(input int n);
        int r;
        r = 1;
        for (int i = 0; i < n; i++) begin
            r = r * 10;
        end
        return r;
    endfunction

    // Bytes in one frame: fixed text plus two "i." fields and their fraction digits.
    function automatic int frame_len(input int frac_digits, input int n_minus);
        return 22 + 2 * frac_digits + n_minus;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: converts IN_W bits to DIGITS BCD digits in IN_W clocks after start.
module bin2bcd_seq #(
    parameter int IN_W   = 8,
    parameter int DIGITS = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [IN_W-1:0]       bin,
    output logic                  done,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int CNT_W = $clog2(IN_W + 1);

    logic [IN_W-1:0]     sh_q, sh_d;
    logic [4*DIGITS-1:0] bcd_q, bcd_d, adj;
    logic [CNT_W-1:0]    cnt_q, cnt_d;

    always_comb begin
        sh_d  = sh_q;
        bcd_d = bcd_q;
        cnt_d = cnt_q;
        adj   = bcd_q;
        for (int d = 0; d < DIGITS; d++) begin
            if (adj[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = adj[4*d +: 4] + 4'd3;
            end
        end
        if (start) begin
            sh_d  = bin;
            bcd_d = '0;
            cnt_d = '0;
        end else if (cnt_q != CNT_W'(IN_W)) begin
            bcd_d = (4*DIGITS)'({adj, sh_q[IN_W-1]});
            sh_d  = sh_q << 1;
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= CNT_W'(IN_W);
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        sh_q  <= sh_d;
        bcd_q <= bcd_d;
    end

    assign done = (cnt_q == CNT_W'(IN_W));
    assign bcd  = bcd_q;

endmodule

// File: rtl/drive_json_framer.sv
// Serializes two signed wheel speeds into {"T":t,"L":x.y,"R":x.y}\n over a valid/ready byte stream.
// Optional periodic resend is compiled in with `define DRIVE_HEARTBEAT_EN.
module drive_json_framer
    import drive_json_pkg::*;
#(
    parameter int SPD_W            = 8,
    parameter int FRAC_DIGITS      = 1,
    parameter int CMD_TYPE         = 1,
    parameter int HEARTBEAT_CYCLES = 1_562_500
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [SPD_W-1:0] left_spd,
    input  logic [SPD_W-1:0] right_spd,
    input  logic             send_req,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    output logic             busy,
    output logic             frame_done,
    output logic             clamped
);

    localparam int FD    = FRAC_DIGITS;
    localparam int BCD_W = 4 * (FD + 1);
    localparam logic [SPD_W-1:0] LIMIT    = SPD_W'(pow10(FD));
    localparam logic [7:0]       CMD_CHAR = ZERO + 8'(CMD_TYPE);
    localparam logic [5:0]       BASE_LAST = 6'(frame_len(FD, 0) - 1);

    if (FD < 1 || FD > 3 || CMD_TYPE < 0 || CMD_TYPE > 9 || HEARTBEAT_CYCLES < 1 ||
        pow10(FD) >= (1 << (SPD_W - 1))) begin : g_param_check
        $error("drive_json_framer: illegal parameter combination");
    end

    state_t           state_q, state_d;
    logic [SPD_W-1:0] snap_l_q, snap_l_d, snap_r_q, snap_r_d;
    logic             neg_l_q, neg_l_d, neg_r_q, neg_r_d;
    logic             pending_q, pending_d;
    logic [5:0]       idx_q, idx_d;
    logic [7:0]       tx_data_q, tx_data_d;
    logic             tx_valid_q, tx_valid_d;
    logic             busy_q, busy_d;
    logic             frame_done_q, frame_done_d;
    logic             clamped_q, clamped_d;

    logic [SPD_W-1:0] raw_l, raw_r, mag_l, mag_r;
    logic             over_l, over_r, trigger, hb_hit;
    logic             conv_done_l, conv_done_r;
    logic [BCD_W-1:0] bcd_l, bcd_r;
    logic [5:0]       last_idx;

    // Absolute value fits SPD_W unsigned bits, so the most negative input is still exact.
    assign raw_l  = left_spd[SPD_W-1]  ? (~left_spd + SPD_W'(1))  : left_spd;
    assign raw_r  = right_spd[SPD_W-1] ? (~right_spd + SPD_W'(1)) : right_spd;
    assign over_l = (raw_l > LIMIT);
    assign over_r = (raw_r > LIMIT);
    assign mag_l  = over_l ? LIMIT : raw_l;
    assign mag_r  = over_r ? LIMIT : raw_r;

    assign trigger = (state_q == IDLE) &&
                     ((left_spd != snap_l_q) || (right_spd != snap_r_q) ||
                      send_req || pending_q || hb_hit);

`ifdef DRIVE_HEARTBEAT_EN
    localparam int HB_W = $clog2(HEARTBEAT_CYCLES) + 1;
    localparam logic [HB_W-1:0] HB_LAST = HB_W'(HEARTBEAT_CYCLES - 1);

    logic [HB_W-1:0] hb_q, hb_d;

    assign hb_hit = (hb_q == HB_LAST);

    always_comb begin
        hb_d = hb_q;
        if (state_q == IDLE) begin
            if (trigger) begin
                hb_d = '0;
            end else if (!hb_hit) begin
                hb_d = hb_q + HB_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hb_q <= '0;
        end else begin
            hb_q <= hb_d;
        end
    end
`else
    assign hb_hit = 1'b0;
`endif

    bin2bcd_seq #(.IN_W(SPD_W), .DIGITS(FD + 1)) u_bcd_l (
        .clk   (clk),
        .rst   (rst),
        .start (trigger),
        .bin   (mag_l),
        .done  (conv_done_l),
        .bcd   (bcd_l)
    );

    bin2bcd_seq #(.IN_W(SPD_W), .DIGITS(FD + 1)) u_bcd_r (
        .clk   (clk),
        .rst   (rst),
        .start (trigger),
        .bin   (mag_r),
        .done  (conv_done_r),
        .bcd   (bcd_r)
    );

    function automatic logic [7:0] hdr_byte(input logic [5:0] o, input logic [7:0] first,
                                            input logic [7:0] letter);
        logic [7:0] b;
        case (o)
            6'd0:       b = first;
            6'd1, 6'd3: b = QUOTE;
            6'd2:       b = letter;
            default:    b = COLON;
        endcase
        return b;
    endfunction

    // Offset o inside one speed field: optional '-', integer digit, '.', fraction digits.
    function automatic logic [7:0] val_byte(input logic [5:0] o, input logic neg,
                                            input logic [BCD_W-1:0] bcd);
        logic [5:0] p, d;
        logic [3:0] dig;
        logic [7:0] b;
        p   = o - {5'd0, neg};
        d   = (p == 6'd0) ? 6'(FD) : (6'(FD + 1) - p);
        dig = 4'(bcd >> {d, 2'b00});
        if (neg && o == 6'd0) begin
            b = MINUS;
        end else if (p == 6'd1) begin
            b = DOT;
        end else begin
            b = ZERO + {4'd0, dig};
        end
        return b;
    endfunction

    function automatic logic [7:0] frame_byte(input logic [5:0] i, input logic nl, input logic nr,
                                              input logic [BCD_W-1:0] bl,
                                              input logic [BCD_W-1:0] br);
        logic [5:0] r_hdr, r_val, tail;
        logic [7:0] b;
        r_hdr = 6'd11 + 6'(2 + FD) + {5'd0, nl};
        r_val = r_hdr + 6'd5;
        tail  = r_val + 6'(2 + FD) + {5'd0, nr};
        if (i < 6'd5)         b = hdr_byte(i, LBRACE, 8'h54);
        else if (i == 6'd5)   b = CMD_CHAR;
        else if (i < 6'd11)   b = hdr_byte(i - 6'd6, COMMA, 8'h4C);
        else if (i < r_hdr)   b = val_byte(i - 6'd11, nl, bl);
        else if (i < r_val)   b = hdr_byte(i - r_hdr, COMMA, 8'h52);
        else if (i < tail)    b = val_byte(i - r_val, nr, br);
        else if (i == tail)   b = RBRACE;
        else                  b = LF;
        return b;
    endfunction

    assign last_idx = BASE_LAST + {5'd0, neg_l_q} + {5'd0, neg_r_q};

    always_comb begin
        state_d      = state_q;
        snap_l_d     = snap_l_q;
        snap_r_d     = snap_r_q;
        neg_l_d      = neg_l_q;
        neg_r_d      = neg_r_q;
        pending_d    = pending_q;
        idx_d        = idx_q;
        tx_data_d    = tx_data_q;
        tx_valid_d   = tx_valid_q;
        frame_done_d = 1'b0;
        clamped_d    = 1'b0;

        if (send_req && state_q != IDLE) begin
            pending_d = 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    snap_l_d  = left_spd;
                    snap_r_d  = right_spd;
                    neg_l_d   = left_spd[SPD_W-1] && (mag_l != '0);
                    neg_r_d   = right_spd[SPD_W-1] && (mag_r != '0);
                    clamped_d = over_l || over_r;
                    pending_d = 1'b0;
                    state_d   = CONVERT;
                end
            end
            CONVERT: begin
                if (conv_done_l && conv_done_r) begin
                    state_d    = EMIT;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = LBRACE;
                end
            end
            EMIT: begin
                if (tx_valid_q && tx_ready) begin
                    if (idx_q == last_idx) begin
                        tx_valid_d   = 1'b0;
                        frame_done_d = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        idx_d     = idx_q + 6'd1;
                        tx_data_d = frame_byte(idx_q + 6'd1, neg_l_q, neg_r_q, bcd_l, bcd_r);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            snap_l_q     <= '0;
            snap_r_q     <= '0;
            neg_l_q      <= 1'b0;
            neg_r_q      <= 1'b0;
            pending_q    <= 1'b0;
            idx_q        <= '0;
            tx_data_q    <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            clamped_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_l_q     <= snap_l_d;
            snap_r_q     <= snap_r_d;
            neg_l_q      <= neg_l_d;
            neg_r_q      <= neg_r_d;
            pending_q    <= pending_d;
            idx_q        <= idx_d;
            tx_data_q    <= tx_data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            frame_done_q <= frame_done_d;
            clamped_q    <= clamped_d;
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign clamped    = clamped_q;

endmodule

// File: tb/tb_drive_json_framer.sv
// Directed bench for drive_json_framer: frame text, latency, clamping, backpressure, busy merge, reset abort.
module tb_drive_json_framer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] left_spd = 8'd0;
    logic [7:0] right_spd = 8'd0;
    logic       send_req = 1'b0;
    logic       tx_ready = 1'b1;
    logic [7:0] tx_data;
    logic       tx_valid, busy, frame_done, clamped;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int clamp_cnt = 0;
    int rx_base = 0;
    logic [7:0] rx_q[$];

    always #5 clk = ~clk;

    drive_json_framer #(
        .SPD_W            (8),
        .FRAC_DIGITS      (1),
        .CMD_TYPE         (1),
        .HEARTBEAT_CYCLES (1000)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .left_spd   (left_spd),
        .right_spd  (right_spd),
        .send_req   (send_req),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .busy       (busy),
        .frame_done (frame_done),
        .clamped    (clamped)
    );

    // Record every byte that will be accepted on the next rising edge.
    always @(negedge clk) begin
        if (tx_valid && tx_ready) rx_q.push_back(tx_data);
        if (frame_done) done_cnt++;
        if (clamped) clamp_cnt++;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_str(input string tag, input string obs, input string exp);
        checks++;
        assert (obs == exp) else begin
            errors++;
            $error("FAIL %s: observed '%s' expected '%s'", tag, obs, exp);
        end
    endtask

    // Collect bytes up to and including LF (shown as '|') and compare with the expected text.
    task automatic wait_frame(input string tag, input string exp);
        int    cyc;
        bit    seen;
        int    i;
        string got;
        cyc  = 0;
        seen = 1'b0;
        got  = "";
        while (!seen && cyc < 300) begin
            step(1);
            cyc++;
            for (int k = rx_base; k < rx_q.size(); k++) begin
                if (rx_q[k] == 8'h0A) seen = 1'b1;
            end
        end
        step(2);
        i = rx_base;
        while (i < rx_q.size()) begin
            got = $sformatf("%s%c", got, (rx_q[i] == 8'h0A) ? 8'h7C : rx_q[i]);
            i++;
            if (rx_q[i-1] == 8'h0A) break;
        end
        rx_base = i;
        chk_str(tag, got, exp);
    endtask

    initial begin
        int n;
        int d0;
        int c0;
        logic [7:0] held;
        bit prev;

        step(3);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data", {24'd0, tx_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
        chk("rst_clamped", {31'd0, clamped}, 32'd0);
        rst = 1'b0;
        step(20);
        chk("idle_after_reset_busy", {31'd0, busy}, 32'd0);
        chk("idle_after_reset_bytes", 32'(rx_q.size()), 32'd0);

        // Positive values, first-byte latency and single frame_done.
        d0 = done_cnt;
        c0 = clamp_cnt;
        left_spd  = 8'd5;
        right_spd = 8'd5;
        @(posedge clk);
        #1;
        chk("busy_after_trigger", {31'd0, busy}, 32'd1);
        n = 0;
        while (!tx_valid && n < 50) begin
            step(1);
            n++;
        end
        chk("first_byte_latency", 32'(n), 32'd9);
        wait_frame("frame_pos", "{\"T\":1,\"L\":0.5,\"R\":0.5}|");
        chk("frame_done_once", 32'(done_cnt - d0), 32'd1);
        chk("no_clamp_pos", 32'(clamp_cnt - c0), 32'd0);
        step(100);
        chk("no_resend_held_inputs", 32'(rx_q.size() - rx_base), 32'd0);
        chk("idle_busy", {31'd0, busy}, 32'd0);

        // Negative values.
        left_spd  = 8'hF9;
        right_spd = 8'd3;
        wait_frame("frame_neg_l", "{\"T\":1,\"L\":-0.7,\"R\":0.3}|");
        right_spd = 8'hFD;
        wait_frame("frame_neg_both", "{\"T\":1,\"L\":-0.7,\"R\":-0.3}|");

        // Clamping at both extremes.
        c0 = clamp_cnt;
        left_spd  = 8'd127;
        right_spd = 8'h80;
        wait_frame("frame_clamp", "{\"T\":1,\"L\":1.0,\"R\":-1.0}|");
        chk("clamp_pulse", 32'(clamp_cnt - c0), 32'd1);

        // Zero and exact limit: no '-' on zero, no clamp at 10.
        c0 = clamp_cnt;
        left_spd  = 8'd0;
        right_spd = 8'hF6;
        wait_frame("frame_zero_limit", "{\"T\":1,\"L\":0.0,\"R\":-1.0}|");
        chk("no_clamp_at_limit", 32'(clamp_cnt - c0), 32'd0);

        // Backpressure after 12 accepted bytes of an explicitly requested frame.
        d0 = done_cnt;
        send_req = 1'b1;
        step(1);
        send_req = 1'b0;
        n = 0;
        while ((rx_q.size() - rx_base) < 12 && n < 100) begin
            step(1);
            n++;
        end
        tx_ready = 1'b0;
        held = tx_data;
        chk("stall_byte", {24'd0, held}, 32'h2E);
        for (int k = 0; k < 10; k++) begin
            step(1);
            chk("stall_hold", {23'd0, tx_valid, tx_data}, 32'h12E);
        end
        tx_ready = 1'b1;
        wait_frame("frame_backpressure", "{\"T\":1,\"L\":0.0,\"R\":-1.0}|");
        chk("backpressure_done", 32'(done_cnt - d0), 32'd1);

        // Requests and input change while busy merge into one follow-up frame.
        d0 = done_cnt;
        left_spd  = 8'd3;
        right_spd = 8'd3;
        n = 0;
        while (!tx_valid && n < 30) begin
            step(1);
            n++;
        end
        step(3);
        send_req = 1'b1;
        step(1);
        send_req = 1'b0;
        step(2);
        send_req = 1'b1;
        step(1);
        send_req = 1'b0;
        left_spd = 8'd4;
        wait_frame("busy_frame1", "{\"T\":1,\"L\":0.3,\"R\":0.3}|");
        wait_frame("busy_frame2", "{\"T\":1,\"L\":0.4,\"R\":0.3}|");
        step(100);
        chk("busy_no_third_frame", 32'(rx_q.size() - rx_base), 32'd0);
        chk("busy_done_count", 32'(done_cnt - d0), 32'd2);

        // Reset in the middle of a frame aborts it; the next frame starts from '{'.
        left_spd = 8'd9;
        n = 0;
        while ((rx_q.size() - rx_base) < 8 && n < 100) begin
            step(1);
            n++;
        end
        rst = 1'b1;
        #1;
        chk("abort_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        step(2);
        rst = 1'b0;
        rx_base = rx_q.size();
        wait_frame("frame_after_abort", "{\"T\":1,\"L\":0.9,\"R\":0.3}|");

`ifdef DRIVE_HEARTBEAT_EN
        // Heartbeat frames with constant inputs: 1000 idle clocks plus 33-clock frame.
        n = 0;
        while (!tx_valid && n < 2000) begin
            step(1);
            n++;
        end
        prev = 1'b1;
        n = 0;
        while (n < 2000) begin
            step(1);
            n++;
            if (tx_valid && !prev) break;
            prev = tx_valid;
        end
        chk("heartbeat_spacing", 32'(n), 32'd1033);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/drive_json_framer.md
Name: drive_json_framer

Overview:
- Parametrised successor to the fixed-template motor UART framer.
- Converts two signed wheel-speed words into an ASCII JSON drive frame: `{"T":<t>,"L":<[-]i.f..>,"R":<[-]i.f..>}\n`.
- Emits the frame byte by byte over a valid/ready byte stream into the existing uart_tx.
- Sits between the motion-command logic and uart_tx; supports configurable fraction digits, clamping, change-driven resend, explicit send requests and a heartbeat.

Parameters:
- SPD_W, 8: signed speed input width. Constraint: 10**FRAC_DIGITS < 2**(SPD_W-1).
- FRAC_DIGITS, 1: decimal fraction digits per speed, range 1..3. Speed value = input / 10**FRAC_DIGITS.
- CMD_TYPE, 1: value of the "T" field, single ASCII digit 0..9.
- HEARTBEAT_CYCLES, 1_562_500: idle clocks between unsolicited resends (31.25 ms at 50 MHz).

Ports:
- clk, in, 1: clock.
- rst, in, 1: reset, asynchronous, active-high.
- left_spd, in, SPD_W: signed left wheel speed.
- right_spd, in, SPD_W: signed right wheel speed.
- send_req, in, 1: single-cycle request to send a frame.
- tx_data, out, 8: byte to uart_tx.
- tx_valid, out, 1: tx_data valid.
- tx_ready, in, 1: uart_tx accepts byte.
- busy, out, 1: frame in progress (not IDLE).
- frame_done, out, 1: one-cycle pulse when the last byte is accepted.
- clamped, out, 1: one-cycle pulse at snapshot if either speed was clamped.

Behaviour:
- Reset values: tx_data=0, tx_valid=0, busy=0, frame_done=0, clamped=0, state=IDLE, last-sent snapshot L=R=0, pending=0, heartbeat counter=0. Reset mid-frame aborts immediately; no partial-frame resumption.
- States: IDLE -> CONVERT -> EMIT -> IDLE.
- IDLE, frame trigger = any of:
  - (left_spd,right_spd) differ from the last-sent snapshot;
  - send_req;
  - pending;
  - heartbeat counter == HEARTBEAT_CYCLES-1.
- On the trigger edge:
  - snapshot both inputs; sign = MSB; magnitude = abs value (SPD_W bits, so -2**(SPD_W-1) is representable).
  - magnitude > 10**FRAC_DIGITS: clamp to 10**FRAC_DIGITS and pulse clamped.
  - clear pending and the heartbeat counter; go to CONVERT.
- CONVERT: two bin2bcd_seq instances run in parallel for exactly SPD_W cycles, producing FRAC_DIGITS+1 BCD digits each. Then go to EMIT.
- Latency: tx_valid first rises SPD_W+1 clocks after the trigger edge.
- EMIT: byte index walks the frame:
  - prefix `{"T":`, CMD_TYPE digit, `,"L":`
  - '-' only if the L sign is set and magnitude != 0
  - integer digit, '.', FRAC_DIGITS digits
  - `,"R":`, R value formatted the same way
  - `}`, 0x0A
- Frame length = 22 + 2*FRAC_DIGITS + number of '-' bytes. FRAC_DIGITS=1 gives 24..26 bytes.
- Handshake:
  - byte transfers on clk when tx_valid && tx_ready;
  - while tx_valid && !tx_ready, tx_data is held stable;
  - tx_valid stays high continuously within EMIT, no gaps required;
  - on acceptance of 0x0A: frame_done=1, tx_valid=0, go to IDLE.
- The last-sent snapshot updates at the trigger edge, not at frame end. Input changes during CONVERT/EMIT are detected on return to IDLE by the snapshot compare.
- send_req while busy sets pending; multiple requests merge into one.
- Heartbeat counter increments only in IDLE and saturates at its terminal value.
- Simultaneous triggers produce one frame.

Optional Feature:
- Macro: DRIVE_HEARTBEAT_EN.
- Defined: heartbeat counter and trigger present as above.
- Undefined: counter removed; frames are sent only on input change, send_req or pending. HEARTBEAT_CYCLES is ignored.

Decomposition:
- Package drive_json_pkg:
  - state enum (IDLE, CONVERT, EMIT);
  - ASCII constants (LBRACE, RBRACE, QUOTE, COLON, COMMA, MINUS, DOT, LF, ZERO);
  - function for frame length from FRAC_DIGITS;
  - POW10 lookup function.
- Sub-module bin2bcd_seq:
  - sequential double-dabble;
  - parameters IN_W, DIGITS;
  - ports start, bin, done, bcd.

Test Plan:
- SPD_W=8, FRAC_DIGITS=1, reset then L=5, R=5, tx_ready=1 -> exactly 24 bytes `{"T":1,"L":0.5,"R":0.5}\n`, frame_done once; no further frame with inputs held (heartbeat disabled).
- L=-7, R=3 -> 25 bytes `{"T":1,"L":-0.7,"R":0.3}\n`. Then L=-7, R=-3 -> 26 bytes with two '-'.
- L=127, R=-128 -> clamped pulse, frame `{"T":1,"L":1.0,"R":-1.0}\n`. L=0 with sign cleared -> no '-'.
- Backpressure: tx_ready low for 10 cycles at byte 12 -> tx_data constant, tx_valid high, no byte lost or duplicated.
- Busy behaviour: send_req twice plus an L change during EMIT -> exactly one follow-up frame carrying the new L.
- DRIVE_HEARTBEAT_EN with HEARTBEAT_CYCLES=1000, constant inputs -> frame starts spaced by 1000 + frame duration. Assert rst at byte 8 -> tx_valid low immediately; next frame starts from '{'.
